// File: rtl/pri_integ_pkg.sv
// Shared types and defaults for the PRI coherent integrator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pri_integ_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 12;
  localparam int DEF_RANGE_BINS = 4096;
  localparam int DEF_NUM_PULSES = 16;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pri_acc_ram.sv
// Accumulation RAM: simple dual port, one write and one read port on one clock.
// Latency: read data registered, valid one clock after the address.
// Backpressure: none; both ports accept every cycle.
module pri_acc_ram #(
  parameter int AW    = 12,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // Write port; contents are never reset, pulse 0 of each frame overwrites them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pri_coherent_integrator.sv
// Sums NUM_PULSES consecutive PRIs bin-by-bin, streams the integrated sweep on the last pulse.
// Latency: accepted sample -> out_valid exactly 2 clocks, one sample per clock.
// Backpressure: none; samples outside an acquisition window are dropped.
module pri_coherent_integrator
  import pri_integ_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int RANGE_BINS = DEF_RANGE_BINS,
  parameter int NUM_PULSES = DEF_NUM_PULSES,
  parameter int AW         = 12,
  parameter int ACC_W      = WIDTH + 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prf_sync,
  input  logic                    din_valid,
  input  logic signed [WIDTH-1:0] din,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_data,
  output logic [AW-1:0]           out_bin,
  output logic                    sweep_done,
  output logic                    sync_err,
  output logic                    busy
);

  localparam int PW = (NUM_PULSES > 1) ? clog2(NUM_PULSES) : 1;
  localparam logic [AW-1:0] LAST_BIN   = AW'(RANGE_BINS - 1);
  localparam logic [PW-1:0] LAST_PULSE = PW'(NUM_PULSES - 1);

  if (ACC_W < WIDTH + clog2(NUM_PULSES)) begin : g_acc_w_check
    $error("ACC_W too narrow for NUM_PULSES");
  end
  if ((1 << AW) < RANGE_BINS) begin : g_aw_check
    $error("AW too narrow for RANGE_BINS");
  end

  state_t          state, state_n;
  logic [AW-1:0]   bin, bin_n;
  logic [PW-1:0]   pulse, pulse_n;
  logic            cap;
  logic [AW-1:0]   cap_bin;
  logic [PW-1:0]   cap_pulse;
  logic            err;

  logic                    v1, first1, last1;
  logic [AW-1:0]           bin1;
  logic signed [ACC_W-1:0] ext1, ram_q, acc;

  // Control registers: state, bin and pulse counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      bin   <= '0;
      pulse <= '0;
    end else begin
      state <= state_n;
      bin   <= bin_n;
      pulse <= pulse_n;
    end
  end

  // Next-state logic; decides whether this cycle's sample is captured and where.
  always_comb begin
    state_n   = state;
    bin_n     = bin;
    pulse_n   = pulse;
    cap       = 1'b0;
    cap_bin   = bin;
    cap_pulse = pulse;
    err       = 1'b0;
    unique case (state)
      IDLE: begin
        if (prf_sync) begin
          state_n   = ACQ;
          bin_n     = '0;
          pulse_n   = '0;
          cap       = din_valid;
          cap_bin   = '0;
          cap_pulse = '0;
        end
      end
      WAIT: begin
        if (prf_sync) begin
          state_n   = ACQ;
          bin_n     = '0;
          pulse_n   = (pulse == LAST_PULSE) ? '0 : pulse + 1'b1;
          cap       = din_valid;
          cap_bin   = '0;
          cap_pulse = pulse_n;
        end
      end
      ACQ: begin
        if (prf_sync) begin
          // Premature sync: abandon the frame and restart at pulse 0, bin 0.
          err       = 1'b1;
          bin_n     = '0;
          pulse_n   = '0;
          cap       = din_valid;
          cap_bin   = '0;
          cap_pulse = '0;
        end else begin
          cap = din_valid;
        end
      end
      default: state_n = IDLE;
    endcase
    if (cap) begin
      if (cap_bin == LAST_BIN) begin
        state_n = WAIT;
        bin_n   = '0;
      end else begin
        bin_n = cap_bin + 1'b1;
      end
    end
  end

  pri_acc_ram #(.AW(AW), .DW(ACC_W)) u_ram (
    .clk     (clk),
    .wr_en   (v1 & ~last1),
    .wr_addr (bin1),
    .wr_data (acc),
    .rd_addr (cap_bin),
    .rd_data (ram_q)
  );

  // Stage 1: hold the captured sample alongside the RAM read in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1     <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
      bin1   <= '0;
      ext1   <= '0;
    end else begin
      v1     <= cap;
      first1 <= (cap_pulse == '0);
      last1  <= (cap_pulse == LAST_PULSE);
      bin1   <= cap_bin;
      ext1   <= {{(ACC_W-WIDTH){din[WIDTH-1]}}, din};
    end
  end

  // Pulse 0 ignores stale RAM contents; later pulses add onto the running sum.
  assign acc = first1 ? ext1 : ram_q + ext1;

  // Output registers: integrated sample on the last pulse, plus status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_bin    <= '0;
      sweep_done <= 1'b0;
      sync_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      out_valid  <= v1 & last1;
      sweep_done <= v1 & last1 & (bin1 == LAST_BIN);
      sync_err   <= err;
      busy       <= (state_n != IDLE);
      if (v1 & last1) begin
        out_data <= acc;
        out_bin  <= bin1;
      end
    end
  end

endmodule

// File: tb/tb_pri_coherent_integrator.sv
// Randomized and directed bench for pri_coherent_integrator against a frame-level model.
// Two instances share stimulus: 4-pulse integration and single-pulse pass-through.
// Outputs are compared 1 time unit after each rising edge.
module tb_pri_coherent_integrator;

  localparam int WIDTH = 12;
  localparam int RB    = 8;
  localparam int AW    = 4;
  localparam int ACC_W = 14;
  localparam int NP0   = 4;
  localparam int NP1   = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic prf_sync = 1'b0;
  logic din_valid = 1'b0;
  logic signed [WIDTH-1:0] din = '0;

  logic ov0, ov1, sw0, sw1, se0, se1, bz0, bz1;
  logic signed [ACC_W-1:0] od0, od1;
  logic [AW-1:0] ob0, ob1;

  always #5 clk = ~clk;

  pri_coherent_integrator #(.WIDTH(WIDTH), .RANGE_BINS(RB), .NUM_PULSES(NP0), .AW(AW), .ACC_W(ACC_W)) u_dut0 (
    .clk(clk), .rst(rst), .prf_sync(prf_sync), .din_valid(din_valid), .din(din),
    .out_valid(ov0), .out_data(od0), .out_bin(ob0), .sweep_done(sw0), .sync_err(se0), .busy(bz0)
  );

  pri_coherent_integrator #(.WIDTH(WIDTH), .RANGE_BINS(RB), .NUM_PULSES(NP1), .AW(AW), .ACC_W(ACC_W)) u_dut1 (
    .clk(clk), .rst(rst), .prf_sync(prf_sync), .din_valid(din_valid), .din(din),
    .out_valid(ov1), .out_data(od1), .out_bin(ob1), .sweep_done(sw1), .sync_err(se1), .busy(bz1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: mode 0 idle, 1 acquiring, 2 waiting for next sync.
  int m_mode[2], m_bin[2], m_pulse[2];
  int acc[2][RB];
  bit ev_now[2], ev_next[2], es_now[2], es_next[2], e_err[2];
  int ed_now[2], ed_next[2], eb_now[2], eb_next[2];
  bit e_rst;

  int last_sw0;
  int n_err0;

  task automatic model_edge(input int k, input logic r, input logic ps, input logic dv, input int d);
    int np;
    bit cap;
    np = (k == 0) ? NP0 : NP1;
    cap = 1'b0;
    ev_now[k] = ev_next[k];
    ed_now[k] = ed_next[k];
    eb_now[k] = eb_next[k];
    es_now[k] = es_next[k];
    ev_next[k] = 1'b0;
    es_next[k] = 1'b0;
    e_err[k] = 1'b0;
    if (!r) begin
      m_mode[k] = 0; m_bin[k] = 0; m_pulse[k] = 0;
      ev_now[k] = 1'b0; es_now[k] = 1'b0;
      return;
    end
    if (ps) begin
      if (m_mode[k] == 1) begin
        e_err[k] = 1'b1;
        m_pulse[k] = 0;
      end else if (m_mode[k] == 2) begin
        m_pulse[k] = (m_pulse[k] + 1) % np;
      end else begin
        m_pulse[k] = 0;
      end
      m_mode[k] = 1;
      m_bin[k] = 0;
      cap = dv;
    end else begin
      cap = (m_mode[k] == 1) && dv;
    end
    if (cap) begin
      if (m_pulse[k] == 0) acc[k][m_bin[k]] = d;
      else acc[k][m_bin[k]] += d;
      if (m_pulse[k] == np - 1) begin
        ev_next[k] = 1'b1;
        ed_next[k] = acc[k][m_bin[k]];
        eb_next[k] = m_bin[k];
        es_next[k] = (m_bin[k] == RB - 1);
      end
      if (m_bin[k] == RB - 1) begin
        m_mode[k] = 2;
        m_bin[k] = 0;
      end else begin
        m_bin[k]++;
      end
    end
  endtask

  task automatic compare(input int k);
    bit v, sw, se, bz;
    int dat, bn;
    if (k == 0) begin v = ov0; sw = sw0; se = se0; bz = bz0; dat = od0; bn = ob0; end
    else        begin v = ov1; sw = sw1; se = se1; bz = bz1; dat = od1; bn = ob1; end
    chk($sformatf("out_valid%0d", k), v, ev_now[k]);
    if (ev_now[k] && v) begin
      chk($sformatf("out_data%0d", k), dat, ed_now[k]);
      chk($sformatf("out_bin%0d", k), bn, eb_now[k]);
    end
    chk($sformatf("sweep_done%0d", k), sw, es_now[k]);
    chk($sformatf("sync_err%0d", k), se, e_err[k]);
    chk($sformatf("busy%0d", k), bz, m_mode[k] != 0);
    if (e_rst) begin
      chk($sformatf("rst_data%0d", k), dat, 0);
      chk($sformatf("rst_bin%0d", k), bn, 0);
    end
    if (k == 0 && sw) last_sw0 = dat;
    if (k == 0 && se) n_err0++;
  endtask

  task automatic step(input logic r, input logic ps, input logic dv, input int d);
    rst = r;
    prf_sync = ps;
    din_valid = dv;
    din = d[WIDTH-1:0];
    @(posedge clk);
    e_rst = !r;
    model_edge(0, r, ps, dv, d);
    model_edge(1, r, ps, dv, d);
    #1;
    compare(0);
    compare(1);
  endtask

  // One PRI: sync with a coincident first sample, then up to nsamp samples over period cycles.
  // gap: 0 = back-to-back, 1 = 1,0,1,1,0 pattern, 2 = random. dmode: 0 = index, 1 = constant, 2 = random.
  task automatic pri(input int nsamp, input int period, input int gap, input int dmode, input int cval);
    int s;
    logic [4:0] pat;
    s = 0;
    pat = 5'b01101;
    for (int i = 0; i < period; i++) begin
      bit ps, dv, en;
      int d;
      ps = (i == 0);
      en = (gap == 0) ? 1'b1 : (gap == 1) ? pat[i % 5] : ($urandom_range(0, 3) != 0);
      dv = (s < nsamp) && en;
      d = (dmode == 0) ? s : (dmode == 1) ? cval : int'($urandom_range(0, 4095)) - 2048;
      step(1'b1, ps, dv, d);
      if (dv) s++;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_bin[k] = 0; m_pulse[k] = 0;
      ev_next[k] = 0; es_next[k] = 0; ed_next[k] = 0; eb_next[k] = 0;
    end
    n_err0 = 0;

    // Reset, then a few idle cycles with stray samples that must be dropped.
    repeat (3) step(1'b0, 1'b0, 1'b0, 0);
    repeat (4) step(1'b1, 1'b0, 1'b1, 7);

    // Ramp: din = bin index, 4 pulses -> sums 0,4,...,28.
    last_sw0 = -1;
    repeat (NP0) pri(8, 20, 0, 0, 0);
    chk("ramp_last_bin", last_sw0, 28);

    // Full-scale constants.
    last_sw0 = -1;
    repeat (NP0) pri(8, 20, 0, 1, -2048);
    chk("neg_fullscale", last_sw0, -8192);
    last_sw0 = -1;
    repeat (NP0) pri(8, 20, 0, 1, 2047);
    chk("pos_fullscale", last_sw0, 8188);

    // Gapped input.
    repeat (NP0) pri(8, 20, 1, 2, 0);

    // Premature sync after 5 bins of pulse 2, then a clean frame over stale RAM.
    n_err0 = 0;
    pri(8, 20, 0, 2, 0);
    pri(8, 20, 0, 2, 0);
    pri(5, 5, 0, 2, 0);
    repeat (NP0) pri(8, 20, 0, 2, 0);
    chk("premature_err_count", n_err0, 1);

    // Reset during pulse 1, then a clean frame.
    pri(8, 20, 0, 2, 0);
    pri(4, 4, 0, 2, 0);
    step(1'b0, 1'b0, 1'b1, 3);
    chk("rst_busy", bz0, 0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 0);
    repeat (NP0) pri(8, 20, 0, 2, 0);

    // Oversized pulses: samples past bin 7 are dropped.
    repeat (NP0) pri(12, 20, 0, 2, 0);

    // Single-pulse pass-through of a coincident sample.
    repeat (NP0) pri(8, 20, 0, 1, 5);

    // Random PRIs: truncated pulses, gaps, occasional reset.
    for (int n = 0; n < 60; n++) begin
      int ns;
      ns = $urandom_range(4, 12);
      if ($urandom_range(0, 19) == 0) step(1'b0, 1'b0, 1'b0, 0);
      pri(ns, $urandom_range(ns, ns + 12), $urandom_range(0, 2), 2, 0);
    end

    repeat (6) step(1'b1, 1'b0, 1'b0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pri_coherent_integrator.md
Name: pri_coherent_integrator

Overview:
- Receive-side stage downstream of the IF LFM pulse generator. Consumes the IF sample stream one PRI at a time.
- Coherently sums NUM_PULSES consecutive PRIs bin-by-bin in an on-chip accumulation RAM. Sums the last pulse's samples on the fly and streams the integrated sweep out.
- Feeds pulse compression / detection. Sample-by-sample sums raise SNR by NUM_PULSES before range processing.

Parameters:
- WIDTH, 12, input sample width, two's-complement signed.
- RANGE_BINS, 4096, samples captured per PRI starting at prf_sync; must be ≥ 2.
- NUM_PULSES, 16, PRIs integrated per frame; must be ≥ 1.
- AW, 12, bin address width; must satisfy 2^AW ≥ RANGE_BINS.
- ACC_W, WIDTH+4, accumulator width; must be ≥ WIDTH+ceil(log2(NUM_PULSES)), which guarantees no overflow.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- prf_sync  in  1  one-cycle pulse marking PRI start (generator PRI counter == 0)
- din_valid  in  1  din qualifier
- din  in  WIDTH  IF sample, signed
- out_valid  out  1  out_data/out_bin valid
- out_data  out  ACC_W  integrated sample, signed
- out_bin  out  AW  range bin of out_data
- sweep_done  out  1  one-cycle pulse with the last bin of a frame
- sync_err  out  1  one-cycle pulse on premature prf_sync
- busy  out  1  high outside IDLE

Behaviour:
- Reset: rst==0 at a clock edge clears all registered outputs to 0 and forces state IDLE, bin=0, pulse=0.
  - RAM contents are not cleared. The first pulse of every frame overwrites them.
- States:
  - IDLE: inputs ignored; prf_sync moves to ACQ, bin=0, pulse=0.
  - ACQ: each din_valid captures bin `bin`, then bin+1. After bin RANGE_BINS-1 is captured, move to WAIT.
  - WAIT: din ignored. prf_sync moves to ACQ, bin=0, pulse+1. If pulse was NUM_PULSES-1, pulse=0 instead (new frame).
- The cycle that carries prf_sync in IDLE or WAIT also accepts a simultaneous din_valid sample as bin 0 of the new pulse.
- Per captured sample, pipelined at one sample per clock with no stalls:
  - Cycle t: RAM read issued at bin.
  - Cycle t+1: sum = RAM_q + sign_extend(din_d1).
  - Pulse 0: RAM[bin] <= sign_extend(din); the stored value is ignored.
  - Pulses 1..N-2: RAM[bin] <= sum.
  - Pulse N-1: no write. out_data <= sum, out_bin <= bin, out_valid <= 1, all registered at the t+2 edge.
  - When NUM_PULSES == 1, pulse 0 is also the last pulse: out_data = sign_extend(din).
- Latency: an accepted sample appears on out_valid exactly 2 clocks later. Gaps in din_valid reproduce as gaps in out_valid.
- No read-after-write hazard: consecutive accepted samples always have distinct, increasing bins.
- sweep_done is asserted with the out_valid for bin RANGE_BINS-1 of pulse N-1.
- prf_sync in ACQ before bin RANGE_BINS-1 is captured:
  - Pulse sync_err on the next cycle.
  - Discard the frame: pulse=0, bin=0, remain in ACQ. A simultaneous din_valid becomes bin 0.
  - Outputs already in the pipeline still drain. No sweep_done is issued for the discarded frame.
- Samples arriving while in WAIT or IDLE are dropped. This includes samples beyond RANGE_BINS, such as the zero tail of the generator's PRI.
- Arithmetic is signed two's complement and saturation-free by construction of ACC_W.
- busy = (state != IDLE), registered. After reset the block stays busy from the first prf_sync onward.

Decomposition:
- Package pri_integ_pkg holds:
  - the state enum (IDLE, ACQ, WAIT);
  - default constants WIDTH, RANGE_BINS, NUM_PULSES;
  - a clog2 function for AW/ACC_W checks.
- Sub-module pri_acc_ram: simple dual-port RAM, depth 2^AW, width ACC_W, one write port and one read port with 1-cycle registered read, same clk. It is inferable as block RAM.
- Control, pipeline and output registers live in the top.

Test Plan:
- RANGE_BINS=8, NUM_PULSES=4, din=bin index in every pulse, prf_sync every 20 clocks → bins 0..7 output with out_data=0,4,...,28; sweep_done with bin 7; latency 2.
- din=-2048 constant, NUM_PULSES=4, ACC_W=14 → every out_data=-8192 (14'h2000). din=+2047 → 8188.
- din_valid toggled 1,0,1,1,0… → identical out_data values, out_valid gaps mirror the input gaps, bins contiguous.
- prf_sync after 5 bins of pulse 2 → sync_err one cycle, no sweep_done; the next clean 4-pulse frame outputs correct sums unaffected by stale RAM.
- rst=0 for one clock during pulse 1 → all outputs 0 next cycle, busy=0. A subsequent frame gives exact sums, with no contribution from the pre-reset pulse.
- prf_sync coincident with din_valid=1, din=5, NUM_PULSES=1 → out_bin=0, out_data=5 two cycles later. 12 samples in a pulse with RANGE_BINS=8 → samples 9–12 produce no output.
